// File: rtl/data_memory_bus.sv
// data_memory_bus: wait-stated byte/halfword/word data memory with little-endian lanes.
// Define DATA_MEMORY_BUS_CLEAR_EN to zero the whole array, one word per cycle, after reset.
module data_memory_bus #(
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 1
) (
    input  logic        Data_Memory_Bus_CLK,
    input  logic        Data_Memory_Bus_RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [1:0]  SIZE,
    input  logic        SIGNED,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        READY,
    output logic        ERR,
    output logic        BUSY,
    output logic [15:0] test_value
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
`ifdef DATA_MEMORY_BUS_CLEAR_EN
    typedef enum logic [1:0] {CLEAR, IDLE, ACCESS} state_t;
    localparam state_t RST_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE, ACCESS} state_t;
    localparam state_t RST_STATE = IDLE;
`endif
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [31:0] a_q, wd_q, rd_q;
    logic [1:0] size_q;
    logic we_q, signed_q, ready_q, err_q;
    logic [31:0] mem [DEPTH];
    logic idle_req, done, err, wr, cur_we, cur_sg;
    logic [1:0] cur_size;
    logic [31:0] cur_a, cur_wd, word, load_val, wdata;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    logic [3:0] be;
    logic [AW-1:0] widx;
`ifdef DATA_MEMORY_BUS_CLEAR_EN
    logic [AW-1:0] clr_q;
    always_ff @(posedge Data_Memory_Bus_CLK or negedge Data_Memory_Bus_RST) begin
        if (!Data_Memory_Bus_RST) clr_q <= '0;
        else if (state_q == CLEAR) clr_q <= clr_q + 1'b1;
    end
`endif
    // The IDLE cycle that sees REQ counts as the first access cycle, so ACCESS
    // itself holds only the WAIT_STATES extra cycles and WAIT_STATES=0 never leaves IDLE.
    always_comb begin
        idle_req = (state_q == IDLE) && REQ;
        cur_a    = (state_q == IDLE) ? A : a_q;
        cur_wd   = (state_q == IDLE) ? WD : wd_q;
        cur_we   = (state_q == IDLE) ? WE : we_q;
        cur_sg   = (state_q == IDLE) ? SIGNED : signed_q;
        cur_size = (state_q == IDLE) ? SIZE : size_q;
        done     = (idle_req && WS == 4'd0) || (state_q == ACCESS && cnt_q == WS);
        err      = (cur_a[31:2] >= 30'(DEPTH)) || (cur_size == 2'b11) ||
                   (cur_size == 2'b01 && cur_a[0]) || (cur_size == 2'b10 && cur_a[1:0] != 2'b00);
        widx     = cur_a[AW+1:2];
        word     = mem[widx];
        byte_v   = 8'(word >> {cur_a[1:0], 3'b000});
        half_v   = cur_a[1] ? word[31:16] : word[15:0];
        load_val = (cur_size == 2'b00) ? {{24{cur_sg & byte_v[7]}}, byte_v} :
                   (cur_size == 2'b01) ? {{16{cur_sg & half_v[15]}}, half_v} : word;
        wdata    = (cur_size == 2'b00) ? {4{cur_wd[7:0]}} :
                   (cur_size == 2'b01) ? {2{cur_wd[15:0]}} : cur_wd;
        be       = (cur_size == 2'b00) ? 4'b0001 << cur_a[1:0] :
                   (cur_size == 2'b01) ? (cur_a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wr       = done && cur_we && !err && Data_Memory_Bus_RST;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (idle_req && WS != 4'd0) begin
            state_d = ACCESS;
            cnt_d   = 4'd1;
        end else if (state_q == ACCESS) begin
            cnt_d   = cnt_q + 4'd1;
            state_d = (cnt_q == WS) ? IDLE : ACCESS;
        end
`ifdef DATA_MEMORY_BUS_CLEAR_EN
        else if (state_q == CLEAR && clr_q == AW'(DEPTH - 1)) state_d = IDLE;
`endif
    end
    always_ff @(posedge Data_Memory_Bus_CLK or negedge Data_Memory_Bus_RST) begin
        if (!Data_Memory_Bus_RST) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            a_q      <= '0;
            wd_q     <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= done;
            if (idle_req) begin
                a_q      <= A;
                wd_q     <= WD;
                size_q   <= SIZE;
                we_q     <= WE;
                signed_q <= SIGNED;
            end
            if (done) begin
                err_q <= err;
                rd_q  <= (err || cur_we) ? '0 : load_val;
            end
        end
    end
    // Memory has no reset; writes are gated by reset so an aborted store never lands.
    always_ff @(posedge Data_Memory_Bus_CLK) begin
`ifdef DATA_MEMORY_BUS_CLEAR_EN
        if (state_q == CLEAR && Data_Memory_Bus_RST) mem[clr_q] <= '0;
`endif
        for (int i = 0; i < 4; i++)
            if (wr && be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
    assign RD         = rd_q;
    assign READY      = ready_q;
    assign ERR        = err_q;
    assign BUSY       = state_q != IDLE;
    assign test_value = mem[0][15:0];
endmodule

// File: doc/data_memory_bus.md
DATA_MEMORY_BUS -- requirements
Module: data_memory_bus

Interface
REQ-001 The module SHALL have parameter DEPTH, default 128, meaning number of 32-bit words stored.
REQ-002 The module SHALL have parameter WAIT_STATES, default 1, meaning extra cycles inserted per access (0..15).
REQ-003 The module SHALL have port Data_Memory_Bus_CLK, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port Data_Memory_Bus_RST, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-005 The module SHALL have port REQ, input, 1, meaning an access request.
REQ-006 The module SHALL have port WE, input, 1, meaning store when 1 and load when 0.
REQ-007 The module SHALL have port SIZE, input, 2, meaning 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 The module SHALL have port SIGNED, input, 1, meaning sign-extend loads when 1 and zero-extend them when 0.
REQ-009 The module SHALL have port A, input, 32, meaning byte address, little-endian.
REQ-010 The module SHALL have port WD, input, 32, meaning store data, right-aligned.
REQ-011 The module SHALL have port RD, output, 32, meaning load result, right-aligned and extended.
REQ-012 The module SHALL have port READY, output, 1, meaning a one-cycle access-complete pulse.
REQ-013 The module SHALL have port ERR, output, 1, meaning the completed access was rejected; valid with READY.
REQ-014 The module SHALL have port BUSY, output, 1, meaning the module is not in IDLE.
REQ-015 The module SHALL have port test_value, output, 16, meaning bits [15:0] of word 0, continuous.

Function
REQ-016 The state machine SHALL have states CLEAR, IDLE and ACCESS; BUSY SHALL be 1 in CLEAR and ACCESS.
REQ-017 In IDLE with REQ=1, the module SHALL latch A, WE, SIZE, SIGNED and WD, and enter ACCESS; REQ SHALL be ignored, not queued, in CLEAR and ACCESS.
REQ-018 ACCESS SHALL last WAIT_STATES+1 cycles; on the exiting edge, state SHALL become IDLE and READY SHALL be 1 for exactly the following cycle.
REQ-019 A REQ in the READY cycle SHALL be accepted, giving one access per WAIT_STATES+1 cycles.
REQ-020 The word index SHALL be A[31:2]; the access SHALL be in error if word index >= DEPTH, SIZE=11, SIZE=01 with A[0]=1, or SIZE=10 with A[1:0]!=0.
REQ-021 An error access SHALL perform no write, drive RD=0 and ERR=1 with READY, and take the same latency as a normal access.
REQ-022 A store SHALL update memory on the exiting ACCESS edge: byte writes WD[7:0] to lane A[1:0], halfword writes WD[15:0] to lanes selected by A[1], word writes all 32 bits; other lanes SHALL be unchanged.
REQ-023 A load SHALL extract the addressed byte, halfword or word and extend it per SIGNED into RD.
REQ-024 A store SHALL return RD=0.
REQ-025 RD and ERR SHALL hold their values until the next READY.

Reset
REQ-026 Reset assertion SHALL immediately force READY=0, ERR=0 and RD=0, and abort any in-flight access without writing.
REQ-027 After reset assertion, state SHALL be CLEAR (macro defined) or IDLE (macro undefined).
REQ-028 The memory array SHALL NOT be reset directly by the reset signal.

Configuration
REQ-029 The macro DATA_MEMORY_BUS_CLEAR_EN SHALL control the clear feature.
REQ-030 With DATA_MEMORY_BUS_CLEAR_EN defined, CLEAR SHALL zero one word per cycle at index 0..DEPTH-1, then enter IDLE after exactly DEPTH cycles.
REQ-031 With DATA_MEMORY_BUS_CLEAR_EN undefined, there SHALL be no CLEAR state and no clear counter, and memory contents after reset SHALL be undefined.

Verification
REQ-032 Scenario: macro defined, DEPTH=128, release reset -> BUSY=1 for 128 cycles, then 0; a word load from A=0x1FC returns RD=0x00000000.
REQ-033 Scenario: WAIT_STATES=1, word store A=0x10, WD=0xDEADBEEF -> READY two cycles after acceptance, ERR=0; a later word load from A=0x10 returns 0xDEADBEEF.
REQ-034 Scenario: byte store 0x80 to A=0x13, then a byte load from A=0x13 with SIGNED=1 returns 0xFFFFFF80, with SIGNED=0 returns 0x00000080, and a word load from A=0x10 returns 0x80ADBEEF.
REQ-035 Scenario: a halfword load from A=0x11, a word store to A=0x202 and an access with SIZE=11 -> each gives READY with ERR=1 and RD=0, and memory is unchanged.
REQ-036 Scenario: REQ held high continuously with WAIT_STATES=0 -> READY every cycle, each READY cycle accepts the next request, and test_value tracks stores to A=0.
REQ-037 Scenario: reset asserted in ACCESS during a store -> READY=0 immediately and the target word keeps its prior value, or is zeroed by CLEAR when the macro is defined.
